shared_mul_arbiter: RTL and testbench

SHARED_MUL_ARBITER -- requirements
Module: shared_mul_arbiter

---
 rtl/shared_mul_pkg.sv | 18 +
 rtl/shared_mul_arbiter_if.sv | 32 +++
 rtl/mul_core.sv | 77 +++++++
 rtl/shared_mul_arbiter.sv | 124 ++++++++++++
 tb/tb_shared_mul_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shared_mul_pkg.sv
// Shared constants for the two-core shift-add multiplier arbiter: FSM encoding,
// default operand width and step-counter width.
package shared_mul_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shared_mul_arbiter_if.sv
// Request/operand/response bundle between two cores and the shared multiplier.
// master = requesting side, slave = arbiter side.
interface shared_mul_arbiter_if
  import shared_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             req0_i;
  logic             req1_i;
  logic [WIDTH-1:0] a0_i;
  logic [WIDTH-1:0] b0_i;
  logic [WIDTH-1:0] a1_i;
  logic [WIDTH-1:0] b1_i;
  logic [1:0]       gnt_o;
  logic             done0_o;
  logic             done1_o;
  logic [WIDTH-1:0] result_o;
  logic             stall0_o;
  logic             stall1_o;

  modport master (
    output req0_i, req1_i, a0_i, b0_i, a1_i, b1_i,
    input  gnt_o, done0_o, done1_o, result_o, stall0_o, stall1_o
  );

  modport slave (
    input  req0_i, req1_i, a0_i, b0_i, a1_i, b1_i,
    output gnt_o, done0_o, done1_o, result_o, stall0_o, stall1_o
  );

endinterface

// File: rtl/mul_core.sv
// Shift-add multiplier datapath: operand latch, accumulator, shifters, step counter.
// Macro SHARED_MUL_EARLY_EXIT_EN ends the operation once the remaining multiplier is zero.
module mul_core
  import shared_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_next_o,
  output logic             last_o
);

  localparam int CW = (WIDTH == DEFAULT_WIDTH) ? DEFAULT_CNT_W : cnt_width(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_step_s;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cnt_last_s;

  // Sum wraps at WIDTH bits, so overflow is dropped for free.
  assign acc_step_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign cnt_last_s = (cnt_q == CW'(WIDTH - 1));
  assign acc_next_o = acc_step_s;

`ifdef SHARED_MUL_EARLY_EXIT_EN
  assign last_o = cnt_last_s || (mplier_q[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
  assign last_o = cnt_last_s;
`endif

  // Next-state for operand latch and one shift-add step per cycle.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = {WIDTH{1'b0}};
      cnt_d    = {CW{1'b0}};
    end else if (step_i) begin
      mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      acc_d    = acc_step_s;
      cnt_d    = cnt_q + CW'(1);
    end else begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/shared_mul_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier between two cores.
// Macro SHARED_MUL_EARLY_EXIT_EN (applied in mul_core) enables early completion.
module shared_mul_arbiter
  import shared_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  shared_mul_arbiter_if.slave  bus
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             both_s;
  logic             winner_s;
  logic             start_s;
  logic             step_s;
  logic             last_s;
  logic [WIDTH-1:0] a_sel_s;
  logic [WIDTH-1:0] b_sel_s;
  logic [WIDTH-1:0] acc_next_s;

  assign both_s   = bus.req0_i & bus.req1_i;
  assign winner_s = both_s ? ptr_q : bus.req1_i;
  assign a_sel_s  = winner_s ? bus.a1_i : bus.a0_i;
  assign b_sel_s  = winner_s ? bus.b1_i : bus.b0_i;

  mul_core #(
    .WIDTH (WIDTH)
  ) u_mul_core (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_s),
    .step_i     (step_s),
    .a_i        (a_sel_s),
    .b_i        (b_sel_s),
    .acc_next_o (acc_next_s),
    .last_o     (last_s)
  );

  // FSM next-state, grant, pointer and completion outputs.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    result_d = {WIDTH{1'b0}};
    start_s  = 1'b0;
    step_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0_i | bus.req1_i) begin
          start_s = 1'b1;
          owner_d = winner_s;
          // A lone requester is either the pointed core or already the
          // non-pointed one, so only a tie moves the pointer.
          ptr_d   = both_s ? ~ptr_q : ptr_q;
          gnt_d   = winner_s ? 2'b10 : 2'b01;
          state_d = MUL;
        end else begin
          gnt_d   = 2'b00;
          state_d = IDLE;
        end
      end
      MUL: begin
        step_s = 1'b1;
        if (last_s) begin
          state_d  = DONE;
          done0_d  = ~owner_q;
          done1_d  = owner_q;
          result_d = acc_next_s;
        end else begin
          state_d = MUL;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b0;
      gnt_q    <= 2'b00;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      result_q <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      result_q <= result_d;
    end
  end

  assign bus.gnt_o    = gnt_q;
  assign bus.done0_o  = done0_q;
  assign bus.done1_o  = done1_q;
  assign bus.result_o = result_q;
  assign bus.stall0_o = bus.req0_i & ~done0_q;
  assign bus.stall1_o = bus.req1_i & ~done1_q;

endmodule

// File: tb/tb_shared_mul_arbiter.sv
// Self-checking bench for shared_mul_arbiter: vector table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_shared_mul_arbiter;

  localparam int W = 32;
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  typedef struct {
    int         core;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    int         lat_fixed;
    int         lat_early;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  shared_mul_arbiter_if #(.WIDTH(W)) bus ();

  shared_mul_arbiter #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycles from the grant cycle (counted as 1) to the done cycle.
  function automatic int lat_of(input logic [W-1:0] b);
`ifdef SHARED_MUL_EARLY_EXIT_EN
    int hi;
    hi = 0;
    for (int i = 0; i < W; i++) if (b[i]) hi = i;
    return hi + 2;
`else
    return W + 1;
`endif
  endfunction

  function automatic logic pick(input logic r0, input logic r1, input logic p);
    return (r0 && r1) ? p : r1;
  endfunction

  // Reference model: one job at a time, product by plain multiplication.
  logic         m_busy  = 1'b0;
  logic         m_done  = 1'b0;
  logic         m_owner = 1'b0;
  logic         m_ptr   = 1'b0;
  int           m_rem   = 0;
  logic [W-1:0] m_prod  = {W{1'b0}};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_owner <= 1'b0; m_ptr <= 1'b0;
      m_rem <= 0; m_prod <= ZERO;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_busy) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) m_done <= 1'b1;
    end else if (bus.req0_i || bus.req1_i) begin
      m_owner <= pick(bus.req0_i, bus.req1_i, m_ptr);
      if (bus.req0_i && bus.req1_i) m_ptr <= !m_ptr;
      if (pick(bus.req0_i, bus.req1_i, m_ptr)) begin
        m_prod <= bus.a1_i * bus.b1_i;
        m_rem  <= lat_of(bus.b1_i) - 1;
      end else begin
        m_prod <= bus.a0_i * bus.b0_i;
        m_rem  <= lat_of(bus.b0_i) - 1;
      end
      m_busy <= 1'b1;
    end
  end

  // Cycle-by-cycle scoreboard against the model.
  always begin
    logic e_d0, e_d1;
    @(posedge clk);
    #2;
    e_d0 = m_done && !m_owner;
    e_d1 = m_done && m_owner;
    chk("sb_gnt", W'(bus.gnt_o), m_busy ? (m_owner ? W'(2'b10) : W'(2'b01)) : ZERO);
    chk("sb_done0", W'(bus.done0_o), W'(e_d0));
    chk("sb_done1", W'(bus.done1_o), W'(e_d1));
    chk("sb_result", bus.result_o, m_done ? m_prod : ZERO);
    chk("sb_stall0", W'(bus.stall0_o), W'(bus.req0_i & ~e_d0));
    chk("sb_stall1", W'(bus.stall1_o), W'(bus.req1_i & ~e_d1));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int c, input logic r, input logic [W-1:0] a, input logic [W-1:0] b);
    if (c == 0) begin
      bus.req0_i = r; bus.a0_i = a; bus.b0_i = b;
    end else begin
      bus.req1_i = r; bus.a1_i = a; bus.b1_i = b;
    end
  endtask

  task automatic drop_req(input int c);
    if (c == 0) bus.req0_i = 1'b0;
    else bus.req1_i = 1'b0;
  endtask

  task automatic wait_done(input int core, input logic [W-1:0] exp_res, input string tag);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      tick();
      n++;
      seen = (core == 0) ? bus.done0_o : bus.done1_o;
      if (seen) chk({tag, "_res"}, bus.result_o, exp_res);
    end
    chk({tag, "_done"}, W'(seen), W'(1'b1));
  endtask

  task automatic run_op(input int core, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic chg, input logic [W-1:0] a_after,
                        input logic [W-1:0] exp_res, input int exp_lat, input string tag);
    int n;
    logic mine, other;
    logic [W-1:0] res;
    @(negedge clk);
    set_req(core, 1'b1, a, b);
    tick();
    chk({tag, "_gnt"}, W'(bus.gnt_o), (core == 0) ? W'(2'b01) : W'(2'b10));
    if (chg) begin
      @(negedge clk);
      set_req(core, 1'b1, a_after, b);
    end
    n = 0; mine = 1'b0; other = 1'b0; res = ZERO;
    while (!mine && n < 200) begin
      tick();
      n++;
      mine  = (core == 0) ? bus.done0_o : bus.done1_o;
      other = other | ((core == 0) ? bus.done1_o : bus.done0_o);
      if (mine) res = bus.result_o;
    end
    chk({tag, "_done"}, W'(mine), W'(1'b1));
    chk({tag, "_lat"}, W'(n + 1), W'(exp_lat));
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_other_done"}, W'(other), ZERO);
    @(negedge clk);
    drop_req(core);
  endtask

  task automatic rand_core(input int c, input logic r, input logic d, input logic g);
    logic [W-1:0] a, b;
    a = $urandom();
    b = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 300)) : $urandom();
    if (!r) begin
      if ($urandom_range(0, 3) == 0) set_req(c, 1'b1, a, b);
    end else if (d) begin
      if ($urandom_range(0, 1) == 0) drop_req(c);
      else set_req(c, 1'b1, a, b);
    end else if (g && $urandom_range(0, 63) == 0) begin
      drop_req(c);
    end else if (g && $urandom_range(0, 7) == 0) begin
      set_req(c, 1'b1, a, b);
    end else begin
      r = r;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   lat, n;
    logic seen;

    set_req(0, 1'b0, ZERO, ZERO);
    set_req(1, 1'b0, ZERO, ZERO);
    vecs[0] = '{0, 32'd7,          32'd6,          32'd42,         33, 4};
    vecs[1] = '{1, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  33, 3};
    vecs[2] = '{0, 32'd9,          32'd1,          32'd9,          33, 2};
    vecs[3] = '{1, 32'd123,        32'd0,          32'd0,          33, 2};
    vecs[4] = '{0, 32'h0001_0000,  32'h0001_0000,  32'd0,          33, 18};
    vecs[5] = '{1, 32'd3,          32'h8000_0000,  32'h8000_0000,  33, 33};
    vecs[6] = '{0, 32'd1000,       32'd1000,       32'd1000000,    33, 11};

    repeat (3) @(posedge clk);
    #2;
    chk("reset_gnt", W'(bus.gnt_o), ZERO);
    chk("reset_done", W'({bus.done1_o, bus.done0_o}), ZERO);
    chk("reset_result", bus.result_o, ZERO);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
`ifdef SHARED_MUL_EARLY_EXIT_EN
      lat = vecs[i].lat_early;
`else
      lat = vecs[i].lat_fixed;
`endif
      run_op(vecs[i].core, vecs[i].a, vecs[i].b, 1'b0, ZERO, vecs[i].exp_res, lat, $sformatf("vec%0d", i));
    end

    // Operands changed right after grant must not matter.
    run_op(0, 32'd5, 32'd5, 1'b1, 32'd100, 32'd25, lat_of(32'd5), "opchg");

    // Simultaneous requests; core 0 keeps requesting after its done.
    @(negedge clk);
    set_req(0, 1'b1, 32'd3, 32'd5);
    set_req(1, 1'b1, 32'd4, 32'd9);
    tick();
    chk("tie1_gnt", W'(bus.gnt_o), W'(2'b01));
    wait_done(0, 32'd15, "tie1");
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.gnt_o != 2'b10 && n < 5);
    chk("tie2_gnt", W'(bus.gnt_o), W'(2'b10));
    chk("tie2_gap", W'(n), W'(2));
    @(negedge clk);
    drop_req(0);
    wait_done(1, 32'd36, "tie2");
    @(negedge clk);
    drop_req(1);
    @(negedge clk);
    set_req(0, 1'b1, 32'd3, 32'd5);
    set_req(1, 1'b1, 32'd4, 32'd9);
    tick();
    chk("tie3_gnt", W'(bus.gnt_o), W'(2'b01));
    wait_done(0, 32'd15, "tie3");
    @(negedge clk);
    drop_req(0);
    wait_done(1, 32'd36, "tie3b");
    @(negedge clk);
    drop_req(1);

    // Reset in the middle of an operation.
    @(negedge clk);
    set_req(0, 1'b1, 32'd11, 32'h8000_0013);
    tick();
    chk("rst_grant", W'(bus.gnt_o), W'(2'b01));
    repeat (10) tick();
    #1;
    rst_n = 1'b0;
    drop_req(0);
    #1;
    chk("rst_gnt", W'(bus.gnt_o), ZERO);
    chk("rst_done0", W'(bus.done0_o), ZERO);
    chk("rst_done1", W'(bus.done1_o), ZERO);
    chk("rst_result", bus.result_o, ZERO);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen = seen | bus.done0_o | bus.done1_o;
    end
    chk("rst_no_done", W'(seen), ZERO);
    run_op(0, 32'd11, 32'h8000_0013, 1'b0, ZERO, 32'h8000_00D1, lat_of(32'h8000_0013), "post_rst");

    // Randomized traffic, checked by the scoreboard.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rand_core(0, bus.req0_i, bus.done0_o, bus.gnt_o[0]);
      rand_core(1, bus.req1_i, bus.done1_o, bus.gnt_o[1]);
    end
    @(negedge clk);
    drop_req(0);
    drop_req(1);
    repeat (80) @(posedge clk);
    #3;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
